// File: rtl/lcd_write_arbiter_pkg.sv
// Shared definitions for the LCD write arbiter.
//   state_e : FSM state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_READY)
//   REQ_ALU : requester index of the MiniAlu instruction stream
//   REQ_DBG : requester index of the status/debug printer
package lcd_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_READY = 2'd3
  } state_e;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Bundle of requester byte streams and the Module_LCD_Control write port.
//   iReq0/iData0/iLast0/oAck0 : requester 0 (MiniAlu) byte handshake
//   iReq1/iData1/iLast1/oAck1 : requester 1 (debug printer) byte handshake
//   iLCD_Ready                : wReady from the LCD controller
//   oLCD_Write/oLCD_Data      : wWrite strobe and wData byte
//   oOwner/oBusy              : current grant holder, arbiter not idle
// master : requesters + LCD side (drives the i* signals)
// slave  : the arbiter (drives the o* signals)
interface lcd_write_arbiter_if;
  logic       iReq0;
  logic [7:0] iData0;
  logic       iLast0;
  logic       oAck0;
  logic       iReq1;
  logic [7:0] iData1;
  logic       iLast1;
  logic       oAck1;
  logic       iLCD_Ready;
  logic       oLCD_Write;
  logic [7:0] oLCD_Data;
  logic       oOwner;
  logic       oBusy;

  modport master (
    output iReq0, iData0, iLast0, iReq1, iData1, iLast1, iLCD_Ready,
    input  oAck0, oAck1, oLCD_Write, oLCD_Data, oOwner, oBusy
  );

  modport slave (
    input  iReq0, iData0, iLast0, iReq1, iData1, iLast1, iLCD_Ready,
    output oAck0, oAck1, oLCD_Write, oLCD_Data, oOwner, oBusy
  );
endinterface

// File: rtl/lcd_write_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector.
//   req_i         : request vector, bit n = requester n
//   ptr_i         : requester favoured when both request
//   grant_valid_o : at least one request present
//   grant_idx_o   : index of the winning requester
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = (&req_i) ? ptr_i : req_i[1];
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Packet-granular round-robin arbiter in front of the Module_LCD_Control
// write port. Each byte is strobed once, then the FSM waits for the
// controller to go busy (or a timeout) and become ready again before the
// next byte. A packet (bytes up to iLast) is never interleaved.
//   Clock : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : requester/LCD handshake bundle (slave side)
module lcd_write_arbiter
  import lcd_write_arbiter_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT  = 4,
  parameter int unsigned INIT_PRIORITY = 0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  lcd_write_arbiter_if.slave   bus
);

  localparam logic [3:0] TIMEOUT   = 4'(BUSY_TIMEOUT);
  localparam logic       INIT_PRIO = 1'(INIT_PRIORITY);

  state_e     state_q;
  logic       write_q;
  logic [7:0] data_q;
  logic       ack0_q;
  logic       ack1_q;
  logic       owner_q;
  logic       busy_q;
  logic       ptr_q;
  logic       last_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic       grant_valid;
  logic       grant_idx;
  logic [7:0] grant_data;
  logic       grant_last;
  logic       own_req;
  logic [7:0] own_data;
  logic       own_last;

  rr_pick2 u_pick (
    .req_i         ({bus.iReq1, bus.iReq0}),
    .ptr_i         (ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    grant_data = (grant_idx == REQ_DBG) ? bus.iData1 : bus.iData0;
    grant_last = (grant_idx == REQ_DBG) ? bus.iLast1 : bus.iLast0;
    own_req    = (owner_q == REQ_DBG) ? bus.iReq1  : bus.iReq0;
    own_data   = (owner_q == REQ_DBG) ? bus.iData1 : bus.iData0;
    own_last   = (owner_q == REQ_DBG) ? bus.iLast1 : bus.iLast0;
    cnt_d      = cnt_q + 4'd1;
  end

  // Strobe, data and ack are loaded on the edge that enters ISSUE so that
  // they are registered yet visible during the ISSUE cycle itself.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      data_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      owner_q <= INIT_PRIO;
      busy_q  <= 1'b0;
      ptr_q   <= INIT_PRIO;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      write_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_valid && bus.iLCD_Ready) begin
            state_q <= ISSUE;
            owner_q <= grant_idx;
            write_q <= 1'b1;
            data_q  <= grant_data;
            last_q  <= grant_last;
            ack0_q  <= (grant_idx == REQ_ALU);
            ack1_q  <= (grant_idx == REQ_DBG);
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          state_q <= WAIT_BUSY;
          cnt_q   <= '0;
        end
        WAIT_BUSY: begin
          if (!bus.iLCD_Ready || (cnt_d == TIMEOUT)) begin
            state_q <= WAIT_READY;
          end
          cnt_q <= cnt_d;
        end
        WAIT_READY: begin
          if (bus.iLCD_Ready) begin
            if (last_q) begin
              state_q <= IDLE;
              ptr_q   <= ~owner_q;
              busy_q  <= 1'b0;
            end else if (own_req) begin
              // Mid-packet: keep the owner, no re-arbitration.
              state_q <= ISSUE;
              write_q <= 1'b1;
              data_q  <= own_data;
              last_q  <= own_last;
              ack0_q  <= (owner_q == REQ_ALU);
              ack1_q  <= (owner_q == REQ_DBG);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oLCD_Write = write_q;
  assign bus.oLCD_Data  = data_q;
  assign bus.oAck0      = ack0_q;
  assign bus.oAck1      = ack1_q;
  assign bus.oOwner     = owner_q;
  assign bus.oBusy      = busy_q;

endmodule
